operand_mem_arbiter: RTL and testbench

Sequencer and two-requester arbiter for the 16-bit operand memory on the PCLK domain. Accepts write-slot and read-pair commands from two requesters over a req/gnt/done handshake and drives the memory's 32-bit address and data ports with the fixed decode addresses. Holds every memory address at 0 when idle. Returns both read operands with a completion pulse. Sits between the operand producers (requester 0 = host/APB side, requester 1 = compute side) and the operand memory.

---
 rtl/operand_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_operand_mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/operand_mem_arbiter.sv
// rtl/operand_mem_arbiter.sv - two-requester round-robin sequencer for the 16-bit operand memory
// Optional build macro: OPARB_FIXED_PRIO_EN (requester 0 always wins ties, no pointer).
module operand_mem_arbiter (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    output logic        busy,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_raddr1,
    output logic [31:0] mem_raddr2,
    output logic [31:0] mem_wdata,
    input  logic [15:0] mem_rdata1,
    input  logic [15:0] mem_rdata2
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_a_q, rdata_a_d;
    logic [15:0] rdata_b_q, rdata_b_d;
    logic        winner;
    logic [1:0]  win_op;

`ifdef OPARB_FIXED_PRIO_EN
    assign winner = ~req0;
`else
    logic ptr_q, ptr_d;

    // ptr_q names the preferred requester when both are asking
    assign winner = (req0 & req1) ? ptr_q : req1;
`endif

    assign win_op = winner ? op1 : op0;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
`ifndef OPARB_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    owner_d = winner;
                    op_d    = win_op;
                    // only writes refresh the data latch so mem_wdata keeps its last written value
                    if (!win_op[1]) begin
                        wdata_d = winner ? wdata1 : wdata0;
                    end
`ifndef OPARB_FIXED_PRIO_EN
                    ptr_d   = ~winner;
`endif
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = op_q[1] ? ST_WAIT : ST_DONE;
            ST_WAIT: begin
                rdata_a_d = mem_rdata1;
                rdata_b_d = mem_rdata2;
                state_d   = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            op_q      <= 2'b00;
            wdata_q   <= 16'h0000;
            rdata_a_q <= 16'h0000;
            rdata_b_q <= 16'h0000;
`ifndef OPARB_FIXED_PRIO_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
`ifndef OPARB_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt0  = (state_q == ST_EXEC) && !owner_q;
    assign gnt1  = (state_q == ST_EXEC) &&  owner_q;
    assign done0 = (state_q == ST_DONE) && !owner_q;
    assign done1 = (state_q == ST_DONE) &&  owner_q;
    assign busy  = (state_q != ST_IDLE);

    // addresses are live only in EXEC; zero matches no decode in the memory
    assign mem_waddr  = (state_q == ST_EXEC && !op_q[1]) ?
                        (op_q[0] ? 32'h2111_0000 : 32'h1111_0000) : 32'h0000_0000;
    assign mem_raddr1 = (state_q == ST_EXEC &&  op_q[1]) ?
                        (op_q[0] ? 32'h2211_1111 : 32'h1211_1111) : 32'h0000_0000;
    assign mem_raddr2 = (state_q == ST_EXEC &&  op_q[1]) ?
                        (op_q[0] ? 32'h2312_2222 : 32'h1312_2222) : 32'h0000_0000;
    assign mem_wdata  = {16'h0000, wdata_q};
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;

endmodule

// File: tb/tb_operand_mem_arbiter.sv
// tb/tb_operand_mem_arbiter.sv - vector-table bench for operand_mem_arbiter with a behavioural memory
module tb_operand_mem_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  op0 = 2'b00, op1 = 2'b00;
    logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [15:0] rdata_a, rdata_b;
    logic [31:0] mem_waddr, mem_raddr1, mem_raddr2, mem_wdata;
    logic [15:0] mem_rdata1 = 16'h0, mem_rdata2 = 16'h0;
    logic [15:0] slot_a = 16'h0, slot_b = 16'h0;

    int total = 0;
    int bad = 0;

    always #5 PCLK = ~PCLK;

    operand_mem_arbiter dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
        .mem_waddr(mem_waddr), .mem_raddr1(mem_raddr1), .mem_raddr2(mem_raddr2),
        .mem_wdata(mem_wdata), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
    );

    function automatic logic [15:0] rom(input logic [31:0] a);
        case (a)
            32'h1211_1111: rom = 16'h0011;
            32'h1312_2222: rom = 16'h0111;
            32'h2211_1111: rom = 16'h1111;
            32'h2312_2222: rom = 16'h1011;
            default:       rom = 16'h0000;
        endcase
    endfunction

    // operand memory: no reset, registered reads
    always @(posedge PCLK) begin
        if (mem_waddr == 32'h1111_0000) slot_a <= mem_wdata[15:0];
        if (mem_waddr == 32'h2111_0000) slot_b <= mem_wdata[15:0];
        mem_rdata1 <= rom(mem_raddr1);
        mem_rdata2 <= rom(mem_raddr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rq;
        logic [1:0]  op;
        logic [15:0] wd;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [15:0] ra;
        logic [15:0] rb;
    } vec_t;

    vec_t vecs[6];

    task automatic run_cmd(input vec_t v);
        int cyc;
        logic rd;
        rd = v.op[1];
        @(negedge PCLK);
        if (v.rq) begin req1 = 1'b1; op1 = v.op; wdata1 = v.wd; end
        else      begin req0 = 1'b1; op0 = v.op; wdata0 = v.wd; end
        cyc = 0;
        do begin @(negedge PCLK); cyc++; end while (!(gnt0 | gnt1) && cyc < 10);
        chk("gnt_latency", cyc, 1);
        chk("gnt_owner", {gnt1, gnt0}, v.rq ? 2'b10 : 2'b01);
        chk("busy_exec", busy, 1'b1);
        if (rd) begin
            chk("raddr1", mem_raddr1, v.a1);
            chk("raddr2", mem_raddr2, v.a2);
            chk("waddr_on_read", mem_waddr, 32'h0);
        end else begin
            chk("waddr", mem_waddr, v.a1);
            chk("wdata", mem_wdata, v.a2);
            chk("raddr_on_write", mem_raddr1 | mem_raddr2, 32'h0);
        end
        req0 = 1'b0; req1 = 1'b0;
        do begin
            @(negedge PCLK); cyc++;
            if (rd && cyc == 2) chk("wait_addr_zero", mem_waddr | mem_raddr1 | mem_raddr2, 32'h0);
        end while (!(done0 | done1) && cyc < 12);
        chk("done_latency", cyc, rd ? 3 : 2);
        chk("done_owner", {done1, done0}, v.rq ? 2'b10 : 2'b01);
        if (rd) begin
            chk("rdata_a", rdata_a, v.ra);
            chk("rdata_b", rdata_b, v.rb);
        end else begin
            chk("slot_readback", v.op[0] ? slot_b : slot_a, v.wd);
        end
        @(negedge PCLK);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        int cyc;
        logic exp_alt[4];

        vecs[0] = '{rq:1'b0, op:2'b00, wd:16'hABCD, a1:32'h1111_0000, a2:32'h0000_ABCD, ra:16'h0, rb:16'h0};
        vecs[1] = '{rq:1'b1, op:2'b11, wd:16'h0000, a1:32'h2211_1111, a2:32'h2312_2222, ra:16'h1111, rb:16'h1011};
        vecs[2] = '{rq:1'b0, op:2'b01, wd:16'h1234, a1:32'h2111_0000, a2:32'h0000_1234, ra:16'h0, rb:16'h0};
        vecs[3] = '{rq:1'b1, op:2'b00, wd:16'h0042, a1:32'h1111_0000, a2:32'h0000_0042, ra:16'h0, rb:16'h0};
        vecs[4] = '{rq:1'b0, op:2'b10, wd:16'hFFFF, a1:32'h1211_1111, a2:32'h1312_2222, ra:16'h0011, rb:16'h0111};
        vecs[5] = '{rq:1'b1, op:2'b10, wd:16'h0000, a1:32'h1211_1111, a2:32'h1312_2222, ra:16'h0011, rb:16'h0111};
`ifdef OPARB_FIXED_PRIO_EN
        exp_alt = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);
        chk("reset_ctrl", {gnt0, gnt1, done0, done1, busy}, 5'b0);
        chk("reset_rdata", {rdata_a, rdata_b}, 32'h0);
        chk("reset_addr", mem_waddr | mem_raddr1 | mem_raddr2, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);
        chk("slot_a_final", slot_a, 16'h0042);
        chk("slot_b_final", slot_b, 16'h1234);
        chk("wdata_held_after_read", mem_wdata, 32'h0000_0042);

        // both requesters held high from a fresh reset: grant order and spacing
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        req0 = 1'b1; op0 = 2'b10; req1 = 1'b1; op1 = 2'b10;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin @(negedge PCLK); cyc++; end while (!(gnt0 | gnt1) && cyc < 10);
            chk($sformatf("alt_owner_%0d", k), {gnt1, gnt0}, exp_alt[k] ? 2'b10 : 2'b01);
            if (k > 0) chk($sformatf("alt_gap_%0d", k), cyc, 4);
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc = 0;
        do begin @(negedge PCLK); cyc++; end while (busy && cyc < 10);
        chk("alt_drain", busy, 1'b0);
        chk("alt_rdata", {rdata_a, rdata_b}, 32'h0011_0111);

        // reset during WAIT discards the read
        op0 = 2'b11; req0 = 1'b1;
        @(negedge PCLK);
        chk("rst_wait_gnt", gnt0, 1'b1);
        req0 = 1'b0;
        @(negedge PCLK);
        chk("rst_wait_busy", busy, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_wait_idle", {busy, done0, done1}, 3'b000);
        chk("rst_wait_rdata", {rdata_a, rdata_b}, 32'h0);
        run_cmd(vecs[1]);

        // reset at the edge ending an EXEC write: memory commits, no done
        op0 = 2'b00; wdata0 = 16'h5555; req0 = 1'b1;
        @(negedge PCLK);
        chk("rst_exec_gnt", gnt0, 1'b1);
        req0 = 1'b0;
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_exec_idle", {busy, done0, done1}, 3'b000);
        chk("rst_exec_commit", slot_a, 16'h5555);
        chk("rst_exec_addr", mem_waddr, 32'h0);
        @(negedge PCLK);
        chk("rst_exec_no_done", {busy, done0, done1}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
